// File: rtl/seg7_scan_display.sv
// Four-digit common-anode seven-segment scanner for the score/time display.
// Registered outputs, leading-zero blanking on tens digits, optional whole-display blink.
module seg7_scan_display #(
  parameter int DIV_WIDTH   = 17,
  parameter int BLINK_WIDTH = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] score_bcd,
  input  logic [7:0] time_bcd,
  input  logic       load,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       scan_tick
);

  localparam logic [DIV_WIDTH-1:0]   PRESCALE_ONE = 1;
  localparam logic [BLINK_WIDTH-1:0] BLINK_ONE    = 1;

  logic [DIV_WIDTH-1:0]   prescaler;
  logic [1:0]             idx;
  logic [1:0]             idx_next;
  logic [BLINK_WIDTH-1:0] blink_cnt;
  logic [BLINK_WIDTH-1:0] blink_next;
  logic [7:0]             score_q;
  logic [7:0]             time_q;
  logic                   tick;
  logic [3:0]             nib;
  logic                   blank;
  logic                   dp;
  logic [7:0]             seg_next;
  logic [3:0]             an_next;

  function automatic logic [7:0] decode(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hBF;
    endcase
    return c;
  endfunction

  // Everything below describes the digit about to be shown, decoded from the
  // shadow registers as they stand before this edge's load takes effect.
  always_comb begin
    tick       = &prescaler;
    idx_next   = idx + 2'd1;
    blink_next = (idx == 2'd3) ? blink_cnt + BLINK_ONE : blink_cnt;
    nib        = '0;
    blank      = 1'b0;
    dp         = 1'b0;
    case (idx_next)
      2'd0: nib = score_q[3:0];
      2'd1: begin
        nib   = score_q[7:4];
        blank = (nib == 4'd0);
      end
      2'd2: begin
        nib = time_q[3:0];
        dp  = 1'b1;
      end
      default: begin
        nib   = time_q[7:4];
        blank = (nib == 4'd0);
      end
    endcase
    seg_next = blank ? 8'hFF : decode(nib);
    if (dp) seg_next[7] = 1'b0;
    an_next = (blink_en && blink_next[BLINK_WIDTH-1]) ? 4'b1111 : ~(4'b0001 << idx_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= 2'd3;
      blink_cnt <= '0;
      score_q   <= '0;
      time_q    <= '0;
      an        <= '1;
      seg       <= '1;
      scan_tick <= 1'b0;
    end else begin
      prescaler <= prescaler + PRESCALE_ONE;
      scan_tick <= tick;
      if (load) begin
        score_q <= score_bcd;
        time_q  <= time_bcd;
      end
      if (tick) begin
        idx       <= idx_next;
        blink_cnt <= blink_next;
        an        <= an_next;
        seg       <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with a 4-cycle slot and 4-frame blink period.
module tb_seg7_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] score_bcd = '0;
  logic [7:0] time_bcd = '0;
  logic       load = 1'b0;
  logic       blink_en = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       scan_tick;

  int checks = 0;
  int errors = 0;
  logic scramble = 1'b0;

  seg7_scan_display #(.DIV_WIDTH(2), .BLINK_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .score_bcd(score_bcd), .time_bcd(time_bcd),
    .load(load), .blink_en(blink_en), .an(an), .seg(seg), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a scan_tick pulse sampled on the falling edge.
  task automatic next_tick(output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      cycles++;
      if (scramble) begin
        score_bcd = 8'($urandom);
        time_bcd  = 8'($urandom);
      end
      if (scan_tick) found = 1'b1;
    end
    check("tick_seen", {7'b0, found}, 8'h01);
  endtask

  task automatic check_digit(input string tag, input logic [3:0] exp_an,
                             input logic [7:0] exp_seg, input int exp_gap);
    int c;
    next_tick(c);
    check({tag, "_gap"}, 8'(c), 8'(exp_gap));
    check({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
    check({tag, "_seg"}, seg, exp_seg);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3,
                           input logic blanked, input int first_gap);
    check_digit({tag, "_d0"}, blanked ? 4'hF : 4'hE, s0, first_gap);
    check_digit({tag, "_d1"}, blanked ? 4'hF : 4'hD, s1, 4);
    check_digit({tag, "_d2"}, blanked ? 4'hF : 4'hB, s2, 4);
    check_digit({tag, "_d3"}, blanked ? 4'hF : 4'h7, s3, 4);
  endtask

  // Reset, then load on the first edge after release (3 cycles then remain to the first tick).
  task automatic reset_load(input logic [7:0] s, input logic [7:0] t, input logic b);
    @(negedge clk);
    rst      = 1'b1;
    load     = 1'b0;
    blink_en = b;
    @(negedge clk);
    rst       = 1'b0;
    score_bcd = s;
    time_bcd  = t;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clk);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", seg, 8'hFF);
    check("rst_tick", {7'b0, scan_tick}, 8'h00);
    rst = 1'b0;
    check_digit("first", 4'hE, 8'hC0, 4);
    check_digit("second", 4'hD, 8'hFF, 4);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_an", {4'h0, an}, 8'h0F);
    check("midrst_seg", seg, 8'hFF);
    check("midrst_tick", {7'b0, scan_tick}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check_digit("restart", 4'hE, 8'hC0, 4);

    reset_load(8'h47, 8'h30, 1'b0);
    run_frame("f4730", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b0, 3);

    reset_load(8'h05, 8'h09, 1'b0);
    run_frame("f0509", 8'h92, 8'hFF, 8'h10, 8'hFF, 1'b0, 3);

    reset_load(8'h00, 8'h00, 1'b0);
    run_frame("f0000", 8'hC0, 8'hFF, 8'h40, 8'hFF, 1'b0, 3);

    reset_load(8'h3C, 8'h00, 1'b0);
    run_frame("f3c00", 8'hBF, 8'hB0, 8'h40, 8'hFF, 1'b0, 3);

    reset_load(8'h47, 8'h30, 1'b1);
    run_frame("blk1", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b0, 3);
    run_frame("blk2", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b1, 4);
    run_frame("blk3", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b1, 4);
    run_frame("blk4", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b0, 4);
    check_digit("blk5_d0", 4'hE, 8'hF8, 4);
    repeat (3) next_tick(c);
    check_digit("blk6_d0", 4'hF, 8'hF8, 4);
    blink_en = 1'b0;
    check_digit("blkoff_d1", 4'hD, 8'h99, 4);

    reset_load(8'h12, 8'h00, 1'b0);
    check_digit("ld_d0", 4'hE, 8'hA4, 3);
    repeat (3) @(negedge clk);
    score_bcd = 8'h34;
    load      = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("ld_edge_tick", {7'b0, scan_tick}, 8'h01);
    check("ld_edge_an", {4'h0, an}, 8'h0D);
    check("ld_edge_seg", seg, 8'hF9);
    check_digit("ld_d2", 4'hB, 8'h40, 4);
    check_digit("ld_d3", 4'h7, 8'hFF, 4);
    check_digit("ld_new_d0", 4'hE, 8'h99, 4);
    check_digit("ld_new_d1", 4'hD, 8'hB0, 4);

    reset_load(8'h47, 8'h30, 1'b0);
    scramble = 1'b1;
    run_frame("hold1", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b0, 3);
    run_frame("hold2", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b0, 4);
    run_frame("hold3", 8'hF8, 8'h99, 8'h40, 8'hB0, 1'b0, 4);
    scramble = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
